// File: rtl/ro_pkg.sv
// Shared types and default sizing for the readout event packer.
// Timestamp storage is only built when RO_TIMESTAMP_EN is defined.
package ro_pkg;

   localparam int RO_N_CH       = 19;
   localparam int RO_CH_W       = 5;
   localparam int RO_TS_W       = 12;
   localparam int RO_FIFO_DEPTH = 8;

   typedef logic [RO_CH_W-1:0] ro_ch_t;

   typedef struct packed {
      ro_ch_t               ch;
      logic                 pol;
      logic [RO_TS_W-1:0]   ts;
   } ro_event_t;

endpackage

// File: rtl/onehot_index.sv
// Encodes a one-hot slot vector into a channel index and flags vectors
// with no bit set (none) or more than one bit set (multi).
module onehot_index
   import ro_pkg::*;
#(
   parameter int N = RO_N_CH,
   parameter int W = RO_CH_W
) (
   input  logic [N-1:0] i_vec,
   output logic [W-1:0] o_index,
   output logic         o_multi,
   output logic         o_none
);

   logic w_seen;

   // Any set bit seen after a previous one marks the vector as multi-hot.
   always_comb begin
      o_index = '0;
      o_multi = 1'b0;
      w_seen  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (i_vec[i]) begin
            if (w_seen) begin
               o_multi = 1'b1;
            end
            w_seen  = 1'b1;
            o_index = W'(i);
         end
      end
   end

   assign o_none = ~|i_vec;

endmodule

// File: rtl/ro_event_packer.sv
// Collects spikes from the shared tristate readout lines, tags them with the
// owning channel (and a timestamp when RO_TIMESTAMP_EN is defined) and queues them.
module ro_event_packer
   import ro_pkg::*;
#(
   parameter int N_CH       = RO_N_CH,
   parameter int CH_W       = RO_CH_W,
   parameter int TS_W       = RO_TS_W,
   parameter int FIFO_DEPTH = RO_FIFO_DEPTH
) (
   input  logic            clk_master,
   input  logic            reset,
   input  logic [N_CH-1:0] gray,
   input  logic            bus_eve,
   input  logic            bus_pol_eve,
   input  logic            ev_ready,
   output logic            ev_valid,
   output logic [CH_W-1:0] ev_channel,
   output logic            ev_pol,
   output logic [TS_W-1:0] ev_ts,
   output logic            err_gray,
   output logic            overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic            r_capEve;
   logic            r_capPol;
   logic [N_CH-1:0] r_grayPrev;
   logic            r_errGray;
   logic            r_overflow;

   logic [N_CH-1:0] w_diff;
   logic [CH_W-1:0] w_ch;
   logic            w_multi;
   logic            w_none;
   logic            w_push;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic            w_accept;

   logic [AW:0]     r_wrPtr;
   logic [AW:0]     r_rdPtr;
   logic [AW-1:0]   w_wrIdx;
   logic [AW-1:0]   w_rdIdx;

   logic [CH_W-1:0]       r_memCh [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] r_memPol;

`ifdef RO_TIMESTAMP_EN
   logic [TS_W-1:0] r_tsCnt;
   logic [TS_W-1:0] r_memTs [FIFO_DEPTH];
`endif

   // Drivers release the bus only after the falling edge, so sampling here is hold-safe.
   always_ff @(negedge clk_master or posedge reset) begin
      if (reset) begin
         r_capEve <= 1'b0;
         r_capPol <= 1'b0;
      end else begin
         r_capEve <= bus_eve;
         r_capPol <= bus_pol_eve;
      end
   end

   assign w_diff = gray ^ r_grayPrev;

   onehot_index #(
      .N (N_CH),
      .W (CH_W)
   ) u_slotDecode (
      .i_vec   (w_diff),
      .o_index (w_ch),
      .o_multi (w_multi),
      .o_none  (w_none)
   );

   assign w_empty  = (r_wrPtr == r_rdPtr);
   assign w_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
   assign w_push   = !w_none && !w_multi && r_capEve;
   assign w_pop    = !w_empty && ev_ready;
   assign w_accept = w_push && (!w_full || w_pop);
   assign w_wrIdx  = r_wrPtr[AW-1:0];
   assign w_rdIdx  = r_rdPtr[AW-1:0];

   // Slot history and the sticky error flags; both flags clear only on reset.
   always_ff @(posedge clk_master or posedge reset) begin
      if (reset) begin
         r_grayPrev <= '0;
         r_errGray  <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_grayPrev <= gray;
         if (w_multi) begin
            r_errGray <= 1'b1;
         end
         if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

`ifdef RO_TIMESTAMP_EN
   always_ff @(posedge clk_master or posedge reset) begin
      if (reset) begin
         r_tsCnt <= '0;
      end else begin
         r_tsCnt <= r_tsCnt + TS_W'(1);
      end
   end
`endif

   // Show-ahead FIFO: contents are cleared on reset so the head reads zero.
   always_ff @(posedge clk_master or posedge reset) begin
      if (reset) begin
         r_wrPtr  <= '0;
         r_rdPtr  <= '0;
         r_memPol <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_memCh[i] <= '0;
`ifdef RO_TIMESTAMP_EN
            r_memTs[i] <= '0;
`endif
         end
      end else begin
         if (w_accept) begin
            r_memCh[w_wrIdx]  <= w_ch;
            r_memPol[w_wrIdx] <= r_capPol;
`ifdef RO_TIMESTAMP_EN
            r_memTs[w_wrIdx]  <= r_tsCnt;
`endif
            r_wrPtr <= r_wrPtr + (AW+1)'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + (AW+1)'(1);
         end
      end
   end

   assign ev_valid   = !w_empty;
   assign ev_channel = r_memCh[w_rdIdx];
   assign ev_pol     = r_memPol[w_rdIdx];
`ifdef RO_TIMESTAMP_EN
   assign ev_ts      = r_memTs[w_rdIdx];
`else
   assign ev_ts      = '0;
`endif
   assign err_gray   = r_errGray;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_ro_event_packer.sv
// Self-checking bench for ro_event_packer: directed slot, sweep, overflow,
// gray-error and reset scenarios plus random traffic against a queue model.
module tb_ro_event_packer;
   import ro_pkg::*;

   localparam int N_CH  = RO_N_CH;
   localparam int CH_W  = RO_CH_W;
   localparam int TS_W  = RO_TS_W;
   localparam int DEPTH = RO_FIFO_DEPTH;

   logic            clkMaster = 1'b0;
   logic            reset     = 1'b1;
   logic [N_CH-1:0] gray      = '0;
   logic            busEve    = 1'b0;
   logic            busPolEve = 1'b0;
   logic            evReady   = 1'b0;
   logic            evValid;
   logic [CH_W-1:0] evChannel;
   logic            evPol;
   logic [TS_W-1:0] evTs;
   logic            errGray;
   logic            overflowFlag;

   int compared   = 0;
   int mismatched = 0;

   ro_event_t       modelQ[$];
   logic [N_CH-1:0] mGrayPrev;
   logic            mErr;
   logic            mOvf;
   logic [TS_W-1:0] mTs;
   int              popHist[N_CH];
   int              popCount;

   always #5 clkMaster = ~clkMaster;

   ro_event_packer dut (
      .clk_master  (clkMaster),
      .reset       (reset),
      .gray        (gray),
      .bus_eve     (busEve),
      .bus_pol_eve (busPolEve),
      .ev_ready    (evReady),
      .ev_valid    (evValid),
      .ev_channel  (evChannel),
      .ev_pol      (evPol),
      .ev_ts       (evTs),
      .err_gray    (errGray),
      .overflow    (overflowFlag)
   );

   function automatic logic [N_CH-1:0] grayOf(input int n);
      int g;
      g = n ^ (n >> 1);
      return N_CH'(g);
   endfunction

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      modelQ.delete();
      mGrayPrev = '0;
      mErr      = 1'b0;
      mOvf      = 1'b0;
      mTs       = '0;
   endtask

   // Applies the slot rules to the inputs that were held during the cycle just ended.
   task automatic modelEdge();
      logic [N_CH-1:0] diff;
      int              ones;
      bit              popNow;
      bit              pushNow;
      ro_event_t       ev;
      diff    = gray ^ mGrayPrev;
      ones    = $countones(diff);
      popNow  = (modelQ.size() > 0) && evReady;
      pushNow = 1'b0;
      ev      = '0;
      if (ones > 1) mErr = 1'b1;
      if (ones == 1 && busEve) begin
         for (int k = 0; k < N_CH; k++) begin
            if (diff[k]) ev.ch = ro_ch_t'(k);
         end
         ev.pol = busPolEve;
`ifdef RO_TIMESTAMP_EN
         ev.ts = mTs;
`endif
         if (modelQ.size() < DEPTH || popNow) pushNow = 1'b1;
         else mOvf = 1'b1;
      end
      if (popNow) void'(modelQ.pop_front());
      if (pushNow) modelQ.push_back(ev);
      mGrayPrev = gray;
      mTs       = mTs + TS_W'(1);
   endtask

   task automatic checkOutput(input string tag);
      checkVal({tag, ".valid"}, 32'(evValid), 32'(modelQ.size() > 0));
      if (modelQ.size() > 0) begin
         checkVal({tag, ".ch"}, 32'(evChannel), 32'(modelQ[0].ch));
         checkVal({tag, ".pol"}, 32'(evPol), 32'(modelQ[0].pol));
         checkVal({tag, ".ts"}, 32'(evTs), 32'(modelQ[0].ts));
      end
      checkVal({tag, ".err"}, 32'(errGray), 32'(mErr));
      checkVal({tag, ".ovf"}, 32'(overflowFlag), 32'(mOvf));
   endtask

   // Drives one slot: inputs change just after a rising edge, checks follow the next one.
   task automatic applyStimulus(input logic [N_CH-1:0] g, input logic eve, input logic pol,
                                input logic rdy, input string tag);
      gray      = g;
      busEve    = eve;
      busPolEve = pol;
      evReady   = rdy;
      if (evValid && rdy) begin
         popCount++;
         if (int'(evChannel) < N_CH) popHist[evChannel]++;
      end
      @(posedge clkMaster);
      modelEdge();
      #1;
      checkOutput(tag);
   endtask

   // Entered just after a rising edge; asserts reset mid-cycle and releases it after a rising edge.
   task automatic doReset(input string tag);
      #2;
      reset     = 1'b1;
      gray      = '0;
      busEve    = 1'b0;
      busPolEve = 1'b0;
      evReady   = 1'b0;
      modelReset();
      #1;
      checkVal({tag, ".rstValid"}, 32'(evValid), 32'(0));
      checkVal({tag, ".rstErr"}, 32'(errGray), 32'(0));
      checkVal({tag, ".rstOvf"}, 32'(overflowFlag), 32'(0));
      repeat (2) @(posedge clkMaster);
      #1;
      checkVal({tag, ".rstCh"}, 32'(evChannel), 32'(0));
      checkVal({tag, ".rstPol"}, 32'(evPol), 32'(0));
      checkVal({tag, ".rstTs"}, 32'(evTs), 32'(0));
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int               gi;
      int               r;
      int               expHist;
      logic [N_CH-1:0]  gCur;

      modelReset();
      popCount = 0;
      foreach (popHist[k]) popHist[k] = 0;

      repeat (3) @(posedge clkMaster);
      #1;
      checkVal("reset.valid", 32'(evValid), 32'(0));
      checkVal("reset.ch", 32'(evChannel), 32'(0));
      checkVal("reset.pol", 32'(evPol), 32'(0));
      checkVal("reset.ts", 32'(evTs), 32'(0));
      checkVal("reset.err", 32'(errGray), 32'(0));
      checkVal("reset.ovf", 32'(overflowFlag), 32'(0));
      reset = 1'b0;

      $display("[TB] single slot decode");
      applyStimulus(grayOf(0), 1'b1, 1'b1, 1'b0, "firstSlot");
      checkVal("firstSlot.noEvent", 32'(evValid), 32'(0));
      applyStimulus(N_CH'(1), 1'b1, 1'b0, 1'b0, "slot0to1");
      checkVal("slot0to1.ch", 32'(evChannel), 32'(0));
      applyStimulus(N_CH'(3), 1'b0, 1'b0, 1'b0, "slot1to3");
      applyStimulus(N_CH'(7), 1'b1, 1'b1, 1'b0, "slot3to7");
      repeat (3) applyStimulus(N_CH'(7), 1'b0, 1'b0, 1'b1, "slotDrain");

      $display("[TB] full sweep");
      doReset("sweep");
      popCount = 0;
      foreach (popHist[k]) popHist[k] = 0;
      applyStimulus(grayOf(0), 1'b1, 1'b0, 1'b1, "sweepFirst");
      for (int i = 1; i <= 1024; i++) begin
         applyStimulus(grayOf(i), 1'b1, 1'($urandom_range(0, 1)), 1'b1, "sweep");
      end
      repeat (4) applyStimulus(grayOf(1024), 1'b0, 1'b0, 1'b1, "sweepDrain");
      checkVal("sweep.count", 32'(popCount), 32'(1024));
      for (int k = 0; k < N_CH; k++) begin
         expHist = (k <= 9) ? (512 >> k) : ((k == 10) ? 1 : 0);
         checkVal($sformatf("sweep.hist%0d", k), 32'(popHist[k]), 32'(expHist));
      end

      $display("[TB] overflow");
      doReset("ovf");
      applyStimulus(grayOf(0), 1'b0, 1'b0, 1'b0, "ovfIdle");
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(grayOf(i), 1'b1, 1'($urandom_range(0, 1)), 1'b0, "ovfFill");
      end
      checkVal("ovf.flag", 32'(overflowFlag), 32'(1));
      popCount = 0;
      repeat (12) applyStimulus(grayOf(10), 1'b0, 1'b0, 1'b1, "ovfDrain");
      checkVal("ovf.drained", 32'(popCount), 32'(8));

      $display("[TB] full with simultaneous push and pop");
      doReset("full");
      applyStimulus(grayOf(0), 1'b0, 1'b0, 1'b0, "fullIdle");
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(grayOf(i), 1'b1, 1'($urandom_range(0, 1)), 1'b0, "fullFill");
      end
      applyStimulus(grayOf(9), 1'b1, 1'b1, 1'b1, "fullPushPop");
      checkVal("full.ovf", 32'(overflowFlag), 32'(0));
      applyStimulus(grayOf(9), 1'b0, 1'b0, 1'b0, "fullStall");
      popCount = 0;
      repeat (10) applyStimulus(grayOf(9), 1'b0, 1'b0, 1'b1, "fullDrain");
      checkVal("full.drained", 32'(popCount), 32'(8));

      $display("[TB] gray error");
      gCur = grayOf(9) ^ N_CH'(3);
      applyStimulus(gCur, 1'b1, 1'b0, 1'b1, "grayErr");
      checkVal("grayErr.flag", 32'(errGray), 32'(1));
      checkVal("grayErr.noPush", 32'(evValid), 32'(0));
      for (int i = 0; i < 5; i++) begin
         gCur = gCur ^ (N_CH'(1) << $urandom_range(0, 4));
         applyStimulus(gCur, 1'b1, 1'($urandom_range(0, 1)), 1'b1, "grayErrHold");
      end
      checkVal("grayErr.sticky", 32'(errGray), 32'(1));

      $display("[TB] reset mid-stream");
      doReset("mid");
      applyStimulus(grayOf(0), 1'b0, 1'b0, 1'b0, "midIdle");
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(grayOf(i), 1'b1, 1'($urandom_range(0, 1)), 1'b0, "midFill");
      end
      doReset("midRst");
      applyStimulus(grayOf(0), 1'b1, 1'b1, 1'b1, "postRstFirst");
      checkVal("postRstFirst.noEvent", 32'(evValid), 32'(0));
      applyStimulus(grayOf(1), 1'b1, 1'b1, 1'b0, "postRstSecond");
      checkVal("postRstSecond.event", 32'(evValid), 32'(1));

      $display("[TB] random traffic");
      doReset("rand");
      gi   = 0;
      gCur = grayOf(0);
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 70) begin
            gi++;
            gCur = grayOf(gi);
         end else if (r >= 98) begin
            gCur = gCur ^ (N_CH'(3) << $urandom_range(0, 10));
         end
         applyStimulus(gCur, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 99) < 60), "random");
      end
      repeat (DEPTH + 2) applyStimulus(gCur, 1'b0, 1'b0, 1'b1, "randDrain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
